shot_controller: RTL and testbench

SHOT_CONTROLLER -- requirements
Module: shot_controller

---
 rtl/bat_shooter_pkg.sv | 26 ++
 rtl/hit_box_check.sv | 22 ++
 rtl/shot_controller.sv | 126 ++++++++++++
 tb/tb_shot_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bat_shooter_pkg.sv
// Shared definitions for the bat shooter: FSM state encodings, frame-tick
// coordinates and small saturating/absolute-difference helpers.
package bat_shooter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONFIRM  = 3'd1,
    ST_FIRE     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_RELEASE  = 3'd4
  } shot_state_t;

  localparam logic [10:0] TICK_X = 11'd1;
  localparam logic [10:0] TICK_Y = 11'd1;
  localparam int          CNT_W  = 5;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 5'd1;
  endfunction

  // Larger minus smaller, so the result never wraps.
  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/hit_box_check.sv
// Combinational square hit box: hit when enabled and both axis distances
// are strictly below the radius.
module hit_box_check
  import bat_shooter_pkg::*;
(
  input  logic [10:0] ax,
  input  logic [10:0] ay,
  input  logic [10:0] bx,
  input  logic [10:0] by,
  input  logic [10:0] radius,
  input  logic        enable,
  output logic        hit
);

  logic [10:0] dx;
  logic [10:0] dy;

  assign dx  = abs_diff(ax, bx);
  assign dy  = abs_diff(ay, by);
  assign hit = enable && (dx < radius) && (dy < radius);

endmodule

// File: rtl/shot_controller.sv
// Click debounce / fire / cooldown FSM for the bat shooter. Click is only
// sampled on frame ticks; all outputs are registered.
module shot_controller
  import bat_shooter_pkg::*;
#(
  parameter int          CLICK_FRAMES    = 2,
  parameter int          COOLDOWN_FRAMES = 15,
  parameter logic [10:0] HIT_RADIUS      = 11'd20,
  parameter logic [7:0]  SCORE_MAX       = 8'd255
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  input  logic [10:0] iX,
  input  logic [10:0] iY,
  input  logic        iClicked,
  input  logic [10:0] iBatX,
  input  logic [10:0] iBatY,
  input  logic        iBatAlive,
  output logic        oFire,
  output logic        oHit,
  output logic [10:0] oShotX,
  output logic [10:0] oShotY,
  output logic [7:0]  oScore,
  output logic [2:0]  oState
);

  localparam logic [CNT_W-1:0] CLICK_N = CNT_W'(CLICK_FRAMES);
  localparam logic [CNT_W-1:0] COOL_N  = CNT_W'(COOLDOWN_FRAMES);

  shot_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             frame_tick;
  logic             hit_now;

  assign frame_tick = (VGA_X == TICK_X) && (VGA_Y == TICK_Y);
  assign cnt_inc    = sat_inc(cnt);
  assign oState     = state;

  // Hit is evaluated against the position being latched, so oHit lines up
  // with the oShotX/oShotY visible during FIRE.
  hit_box_check u_hit_box_check (
    .ax     (iX),
    .ay     (iY),
    .bx     (iBatX),
    .by     (iBatY),
    .radius (HIT_RADIUS),
    .enable (iBatAlive),
    .hit    (hit_now)
  );

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      oFire  <= 1'b0;
      oHit   <= 1'b0;
      oShotX <= '0;
      oShotY <= '0;
      oScore <= '0;
    end else begin
      oFire <= 1'b0;
      oHit  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_tick && iClicked) begin
            cnt <= 5'd1;
            if (CLICK_N == 5'd1) begin
              state  <= ST_FIRE;
              oFire  <= 1'b1;
              oHit   <= hit_now;
              oShotX <= iX;
              oShotY <= iY;
            end else begin
              state <= ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (frame_tick) begin
            if (!iClicked) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == CLICK_N) begin
                state  <= ST_FIRE;
                oFire  <= 1'b1;
                oHit   <= hit_now;
                oShotX <= iX;
                oShotY <= iY;
              end
            end
          end
        end
        ST_FIRE: begin
          state <= ST_COOLDOWN;
          cnt   <= '0;
          if (oHit && (oScore < SCORE_MAX))
            oScore <= oScore + 8'd1;
        end
        ST_COOLDOWN: begin
          if (frame_tick) begin
            cnt <= cnt_inc;
            if (cnt_inc == COOL_N)
              state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // A held click parks here until it drops, preventing autofire.
          if (frame_tick && !iClicked) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_controller.sv
// Self-checking bench for shot_controller: frame-level reference model,
// directed scenarios plus randomized click/position traffic.
module tb_shot_controller;

  localparam int CF   = 2;
  localparam int CD   = 15;
  localparam int RAD  = 20;
  localparam int SMAX = 255;
  localparam int FLEN = 3;

  logic        VGA_CLK = 1'b0;
  logic        reset;
  logic [10:0] VGA_X, VGA_Y, iX, iY, iBatX, iBatY;
  logic        iClicked, iBatAlive;
  logic        oFire, oHit;
  logic [10:0] oShotX, oShotY;
  logic [7:0]  oScore;
  logic [2:0]  oState;

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per frame
  int m_run, m_cd, m_score, m_sx, m_sy;
  bit m_need_rel;
  bit exp_fire, exp_hit;

  int         obs_fires;
  bit         obs_hit;
  logic [2:0] obs_state;

  always #5 VGA_CLK = ~VGA_CLK;

  shot_controller dut (
    .VGA_CLK   (VGA_CLK),
    .reset     (reset),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .iX        (iX),
    .iY        (iY),
    .iClicked  (iClicked),
    .iBatX     (iBatX),
    .iBatY     (iBatY),
    .iBatAlive (iBatAlive),
    .oFire     (oFire),
    .oHit      (oHit),
    .oShotX    (oShotX),
    .oShotY    (oShotY),
    .oScore    (oScore),
    .oState    (oState)
  );

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cd = 0; m_score = 0; m_sx = 0; m_sy = 0; m_need_rel = 0;
  endtask

  task automatic model_tick(input bit click, input int x, input int y,
                            input int bx, input int by, input bit alive);
    exp_fire = 0;
    exp_hit  = 0;
    if (m_cd > 0) begin
      m_cd--;
      if (m_cd == 0) m_need_rel = 1;
    end else if (m_need_rel) begin
      if (!click) m_need_rel = 0;
    end else if (click) begin
      m_run++;
      if (m_run == CF) begin
        exp_fire = 1;
        exp_hit  = alive && (absd(x, bx) < RAD) && (absd(y, by) < RAD);
        m_sx = x;
        m_sy = y;
        if (exp_hit && m_score < SMAX) m_score++;
        m_run = 0;
        m_cd  = CD;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // One frame: tick cycle first, then non-tick scan positions.
  task automatic run_frame(input bit click, input int x, input int y,
                           input int bx, input int by, input bit alive);
    model_tick(click, x, y, bx, by, alive);
    obs_fires = 0;
    obs_hit   = 0;
    for (int c = 0; c < FLEN; c++) begin
      @(negedge VGA_CLK);
      iClicked = click; iX = 11'(x); iY = 11'(y);
      iBatX = 11'(bx); iBatY = 11'(by); iBatAlive = alive;
      if (c == 0) begin
        VGA_X = 11'd1; VGA_Y = 11'd1;
      end else begin
        VGA_X = 11'($urandom_range(0, 799));
        VGA_Y = 11'($urandom_range(2, 524));
      end
      @(posedge VGA_CLK); #1;
      if (oFire) obs_fires++;
      if (oHit) obs_hit = 1;
    end
    obs_state = oState;
  endtask

  task automatic settle();
    for (int f = 0; f < CD + 2; f++) run_frame(0, 0, 0, 600, 600, 1);
  endtask

  task automatic test_reset();
    reset = 1; VGA_X = 11'd1; VGA_Y = 11'd1; iClicked = 1;
    iX = 11'd5; iY = 11'd6; iBatX = 11'd5; iBatY = 11'd6; iBatAlive = 1;
    repeat (3) @(posedge VGA_CLK);
    #1;
    checks++; if (oState !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", oState); end
    checks++; if (oFire !== 1'b0 || oHit !== 1'b0) begin errors++; $display("FAIL reset_pulses got fire=%b hit=%b want 0 0", oFire, oHit); end
    checks++; if (oShotX !== 11'd0 || oShotY !== 11'd0) begin errors++; $display("FAIL reset_shot got %0d,%0d want 0,0", oShotX, oShotY); end
    checks++; if (oScore !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", oScore); end
    @(negedge VGA_CLK);
    reset = 0; VGA_X = 11'd0; VGA_Y = 11'd0; iClicked = 0;
    model_reset();
  endtask

  task automatic test_basic_hit();
    run_frame(1, 300, 200, 310, 190, 1);
    checks++; if (obs_fires !== 0 || obs_state !== 3'd1) begin errors++; $display("FAIL basic_confirm got fires=%0d state=%0d want 0 1", obs_fires, obs_state); end
    run_frame(1, 300, 200, 310, 190, 1);
    checks++; if (obs_fires !== 1) begin errors++; $display("FAIL basic_fire got %0d want 1", obs_fires); end
    checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL basic_hit got %b want 1", obs_hit); end
    checks++; if (oShotX !== 11'd300 || oShotY !== 11'd200) begin errors++; $display("FAIL basic_shot got %0d,%0d want 300,200", oShotX, oShotY); end
    checks++; if (oScore !== 8'd1) begin errors++; $display("FAIL basic_score got %0d want 1", oScore); end
    for (int f = 0; f < CD; f++) run_frame(0, 300, 200, 310, 190, 1);
    checks++; if (obs_state !== 3'd4) begin errors++; $display("FAIL basic_release got %0d want 4", obs_state); end
    run_frame(0, 300, 200, 310, 190, 1);
    checks++; if (obs_state !== 3'd0) begin errors++; $display("FAIL basic_idle got %0d want 0", obs_state); end
  endtask

  task automatic test_short_click();
    run_frame(1, 50, 60, 50, 60, 1);
    checks++; if (obs_state !== 3'd1) begin errors++; $display("FAIL short_confirm got %0d want 1", obs_state); end
    run_frame(0, 50, 60, 50, 60, 1);
    checks++; if (obs_fires !== 0 || obs_state !== 3'd0) begin errors++; $display("FAIL short_abort got fires=%0d state=%0d want 0 0", obs_fires, obs_state); end
  endtask

  task automatic test_hold();
    int total = 0;
    for (int f = 0; f < 40; f++) begin
      run_frame(1, 70, 80, 900, 900, 1);
      total += obs_fires;
    end
    checks++; if (total !== 1) begin errors++; $display("FAIL hold_fires got %0d want 1", total); end
    checks++; if (obs_state !== 3'd4) begin errors++; $display("FAIL hold_release got %0d want 4", obs_state); end
    run_frame(0, 70, 80, 900, 900, 1);
    checks++; if (obs_state !== 3'd0) begin errors++; $display("FAIL hold_idle got %0d want 0", obs_state); end
  endtask

  task automatic test_cooldown();
    int total = 0;
    run_frame(1, 10, 10, 10, 10, 1);
    run_frame(1, 10, 10, 10, 10, 1);
    checks++; if (obs_fires !== 1) begin errors++; $display("FAIL cool_first got %0d want 1", obs_fires); end
    for (int f = 3; f <= 18; f++) begin
      run_frame((f == 11 || f == 12), 20, 20, 10, 10, 1);
      total += obs_fires;
    end
    checks++; if (total !== 0) begin errors++; $display("FAIL cool_ignored got %0d want 0", total); end
    run_frame(1, 30, 30, 10, 10, 1);
    run_frame(1, 30, 30, 10, 10, 1);
    checks++; if (obs_fires !== 1 || oShotX !== 11'd30) begin errors++; $display("FAIL cool_refire got fires=%0d x=%0d want 1 30", obs_fires, oShotX); end
    settle();
  endtask

  task automatic test_radius();
    int bx[7] = '{120, 119, 119, 100, 100, 81, 80};
    int by[7] = '{100, 100, 100, 80, 81, 100, 100};
    bit al[7] = '{1, 1, 0, 1, 1, 1, 1};
    bit eh[7] = '{0, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      run_frame(1, 100, 100, bx[i], by[i], al[i]);
      run_frame(1, 100, 100, bx[i], by[i], al[i]);
      checks++; if (obs_fires !== 1 || obs_hit !== eh[i]) begin errors++; $display("FAIL radius_%0d got fires=%0d hit=%b want 1 %b", i, obs_fires, obs_hit, eh[i]); end
      settle();
    end
    checks++; if (oScore !== 8'(m_score)) begin errors++; $display("FAIL radius_score got %0d want %0d", oScore, m_score); end
  endtask

  task automatic test_random();
    bit click = 0;
    for (int f = 0; f < 300; f++) begin
      int x, y, bx, by;
      if ($urandom_range(0, 3) == 0) click = ~click;
      x  = $urandom_range(0, 2047);
      y  = $urandom_range(0, 2047);
      bx = x + $urandom_range(0, 50) - 25;
      by = y + $urandom_range(0, 50) - 25;
      if (bx < 0) bx = 0; if (bx > 2047) bx = 2047;
      if (by < 0) by = 0; if (by > 2047) by = 2047;
      run_frame(click, x, y, bx, by, $urandom_range(0, 7) != 0);
      checks++; if (obs_fires !== int'(exp_fire)) begin errors++; $display("FAIL rand_fire f%0d got %0d want %0d", f, obs_fires, exp_fire); end
      checks++; if (obs_hit !== exp_hit) begin errors++; $display("FAIL rand_hit f%0d got %b want %b", f, obs_hit, exp_hit); end
      checks++; if (oShotX !== 11'(m_sx) || oShotY !== 11'(m_sy)) begin errors++; $display("FAIL rand_shot f%0d got %0d,%0d want %0d,%0d", f, oShotX, oShotY, m_sx, m_sy); end
      checks++; if (oScore !== 8'(m_score)) begin errors++; $display("FAIL rand_score f%0d got %0d want %0d", f, oScore, m_score); end
    end
    settle();
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 300 && m_score < SMAX; n++) begin
      run_frame(1, 500, 400, 505, 395, 1);
      run_frame(1, 500, 400, 505, 395, 1);
      settle();
    end
    checks++; if (oScore !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", oScore); end
    run_frame(1, 500, 400, 505, 395, 1);
    run_frame(1, 500, 400, 505, 395, 1);
    checks++; if (obs_hit !== 1'b1 || oScore !== 8'd255) begin errors++; $display("FAIL sat_hold got hit=%b score=%0d want 1 255", obs_hit, oScore); end
    settle();
  endtask

  task automatic test_reset_in_fire();
    run_frame(1, 500, 400, 505, 395, 1);
    @(negedge VGA_CLK);
    VGA_X = 11'd1; VGA_Y = 11'd1; iClicked = 1;
    @(posedge VGA_CLK); #1;
    checks++; if (oFire !== 1'b1 || oState !== 3'd2) begin errors++; $display("FAIL rif_fire got fire=%b state=%0d want 1 2", oFire, oState); end
    @(negedge VGA_CLK);
    reset = 1; VGA_X = 11'd0; VGA_Y = 11'd0; iClicked = 0;
    @(posedge VGA_CLK); #1;
    checks++; if (oScore !== 8'd0 || oState !== 3'd0) begin errors++; $display("FAIL rif_reset got score=%0d state=%0d want 0 0", oScore, oState); end
    @(negedge VGA_CLK);
    reset = 0;
    model_reset();
    repeat (3) @(posedge VGA_CLK);
    #1;
    checks++; if (oScore !== 8'd0 || oFire !== 1'b0) begin errors++; $display("FAIL rif_noinc got score=%0d fire=%b want 0 0", oScore, oFire); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    VGA_X = 0; VGA_Y = 0; iX = 0; iY = 0; iBatX = 0; iBatY = 0;
    iClicked = 0; iBatAlive = 0; reset = 1;
    model_reset();
    test_reset();
    test_basic_hit();
    test_short_click();
    test_hold();
    test_cooldown();
    test_radius();
    test_random();
    test_saturate();
    test_reset_in_fire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
